// File: rtl/fft_pkg.sv
// fft_pkg: constants and send-FSM encoding shared between the frame source and the FFT core.
//   DATA_W    - sample width
//   FRAME_LEN - words per frame (power of two)
//   ADDR_W    - log2(FRAME_LEN), width of the in-frame word counters
//   LAST_IDX  - index of the final word of a frame
//   send_state_e - frame sender states (IDLE=00, SEND=01, GAP=10)
package fft_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 32;
    localparam int unsigned ADDR_W    = $clog2(FRAME_LEN);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StGap  = 2'b10
    } send_state_e;

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two-bank sample store, one write port and one registered read port.
//   i_clk, i_rst_n        - clock and synchronous active-low reset (clears the read register only)
//   i_we/i_wbank/i_waddr/i_wdata - write strobe, bank select, word address, data
//   i_re/i_rbank/i_raddr  - read strobe, bank select, word address
//   o_rdata               - read data, updated one cycle after i_re and held while i_re is low
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int unsigned DataW = DATA_W,
    parameter int unsigned AddrW = ADDR_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic             i_wbank,
    input  logic [AddrW-1:0] i_waddr,
    input  logic [DataW-1:0] i_wdata,
    input  logic             i_re,
    input  logic             i_rbank,
    input  logic [AddrW-1:0] i_raddr,
    output logic [DataW-1:0] o_rdata
);

    localparam int unsigned Words = 2 * (2 ** AddrW);

    // Bank select is the address MSB, so bank 0 occupies the low half.
    logic [DataW-1:0] r_mem [Words];
    logic [DataW-1:0] r_rdata;

    // Storage is deliberately not reset: queued frames are discarded by clearing
    // the full flags, not the contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_wbank, i_waddr}] <= i_wdata;
        end
    end

    // Holding the read register when i_re is low is what keeps data_o stable
    // through a stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[{i_rbank, i_raddr}];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_src.sv
// fft_frame_src: collects upstream samples into FRAME_LEN-word frames in a ping-pong buffer
// and ships each complete frame to the FFT core as one req/ans burst.
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-low reset
//   wr_en      - upstream write strobe
//   wr_data    - sample, taken when wr_en && wr_ready
//   wr_ready   - current write bank is not full
//   req_o      - frame request, high for the whole frame
//   ans_i      - core acknowledge; a word moves on each cycle with req_o && ans_i
//   data_o     - current frame word, valid while req_o is high
//   frame_done - one-cycle pulse after the last word of a frame moves
//   overflow   - sticky, set by a write attempted while wr_ready is low
module fft_frame_src
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              req_o,
    input  logic              ans_i,
    output logic [DATA_W-1:0] data_o,
    output logic              frame_done,
    output logic              overflow
);

    send_state_e       r_state;
    send_state_e       w_state_next;
    logic [1:0]        r_full;
    logic [1:0]        w_full_next;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] w_wr_cnt_next;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] w_rd_cnt_next;
    logic              r_frame_done;
    logic              r_overflow;

    logic              w_wr_accept;
    logic              w_wr_last;
    logic              w_send_last;
    logic              w_req;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign wr_ready    = !r_full[r_wr_bank];
    assign w_wr_accept = wr_en && wr_ready;
    assign w_wr_last   = w_wr_accept && (r_wr_cnt == LAST_IDX);

    // FRAME_LEN is a power of two, so the increment wraps to 0 on the last word.
    assign w_wr_cnt_next = w_wr_accept ? r_wr_cnt + ADDR_W'(1) : r_wr_cnt;

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------
    // The read port is only strobed when the next word is needed: on entry to
    // SEND (word 0) and on every non-final handshake (word rd_cnt+1). data_o is
    // therefore one word ahead of rd_cnt's last handshake and holds on stalls.
    always_comb begin
        w_state_next  = r_state;
        w_req         = 1'b0;
        w_rd_en       = 1'b0;
        w_rd_addr     = '0;
        w_rd_cnt_next = r_rd_cnt;
        w_send_last   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (r_full[r_rd_bank]) begin
                    w_state_next  = StSend;
                    w_rd_en       = 1'b1;
                    w_rd_addr     = '0;
                    w_rd_cnt_next = '0;
                end
            end
            StSend: begin
                w_req = 1'b1;
                if (ans_i) begin
                    w_rd_cnt_next = r_rd_cnt + ADDR_W'(1);
                    if (r_rd_cnt == LAST_IDX) begin
                        w_send_last  = 1'b1;
                        w_state_next = StGap;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_rd_cnt + ADDR_W'(1);
                    end
                end
            end
            // One forced low cycle so the core sees req_o fall between frames.
            StGap: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Writer and sender always address different banks, so a set and a clear
    // landing in the same cycle both apply.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_last) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_send_last) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_full       <= w_full_next;
            r_wr_cnt     <= w_wr_cnt_next;
            r_rd_cnt     <= w_rd_cnt_next;
            r_frame_done <= w_send_last;
            r_overflow   <= r_overflow | (wr_en & ~wr_ready);
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_send_last) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    fft_pingpong_ram #(
        .DataW (DATA_W),
        .AddrW (ADDR_W)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_wr_accept),
        .i_wbank (r_wr_bank),
        .i_waddr (r_wr_cnt),
        .i_wdata (wr_data),
        .i_re    (w_rd_en),
        .i_rbank (r_rd_bank),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign req_o      = w_req;
    assign data_o     = w_rd_data;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fft_frame_src.sv
module tb_fft_frame_src;
    import fft_pkg::*;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              wr_en   = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              ans_i   = 1'b0;
    logic              wr_ready;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              frame_done;
    logic              overflow;

    int checks   = 0;
    int errors   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] base;
        int                stall_after;  // word index after whose transfer ans_i drops (-1: none)
        int                stall_len;
        int                exp_len;      // expected cycles with req_o high
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    fft_frame_src dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .req_o      (req_o),
        .ans_i      (ans_i),
        .data_o     (data_o),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshake must deliver the oldest accepted sample.
    always @(negedge clk) begin
        if (rst && req_o && ans_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got 0x%0h, expected no transfer (t=%0t)",
                         data_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("xfer_data", 32'(data_o), 32'(mon_exp));
            end
            xfer_cnt++;
        end
        if (rst && frame_done) begin
            done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        wr_en = 1'b0;
        ans_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic write_frame(input logic [DATA_W-1:0] base);
        for (int i = 0; i < FRAME_LEN; i++) begin
            wr_en   = 1'b1;
            wr_data = base + DATA_W'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int guard;
        guard = 0;
        while (xfer_cnt < target && guard < budget) begin
            tick();
            guard++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int hi;
        int xf;
        int stall_left;
        int guard;
        logic was;
        do_reset();
        ans_i = 1'b1;
        write_frame(v.base);
        chk({v.name, "_req_not_early"}, 32'(req_o), 32'd0);
        tick();
        chk({v.name, "_req_rise"}, 32'(req_o), 32'd1);
        chk({v.name, "_first_word"}, 32'(data_o), 32'(v.base));
        hi = 0;
        xf = 0;
        stall_left = 0;
        guard = 0;
        while (req_o && guard < 200) begin
            guard++;
            hi++;
            if (stall_left > 0) begin
                ans_i = 1'b0;
                chk({v.name, "_stall_data"}, 32'(data_o), 32'(v.base) + 32'(v.stall_after + 1));
            end else begin
                ans_i = 1'b1;
            end
            chk({v.name, "_wr_ready"}, 32'(wr_ready), 32'd1);
            was = ans_i;
            tick();
            if (was) begin
                if (xf == v.stall_after) stall_left = v.stall_len;
                xf++;
            end else begin
                stall_left--;
            end
        end
        chk({v.name, "_req_cycles"}, 32'(hi), 32'(v.exp_len));
        chk({v.name, "_xfers"}, 32'(xf), 32'(FRAME_LEN));
        chk({v.name, "_done_pulse"}, 32'(frame_done), 32'd1);
        tick();
        chk({v.name, "_done_once"}, 32'(frame_done), 32'd0);
        chk({v.name, "_req_low_gap"}, 32'(req_o), 32'd0);
        tick();
        chk({v.name, "_req_low_idle"}, 32'(req_o), 32'd0);
        chk({v.name, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({v.name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        ans_i = 1'b0;
    endtask

    initial begin
        int guard;
        int low;
        int n;

        vecs[0] = '{name: "single",   base: 16'h0000, stall_after: -1, stall_len: 0, exp_len: 32};
        vecs[1] = '{name: "stall7",   base: 16'h0000, stall_after: 7,  stall_len: 3, exp_len: 35};
        vecs[2] = '{name: "stall0",   base: 16'h0A40, stall_after: 0,  stall_len: 1, exp_len: 33};
        vecs[3] = '{name: "stall30",  base: 16'h0B60, stall_after: 30, stall_len: 5, exp_len: 37};

        // Reset state
        do_reset();
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single frames, with and without stalls
        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k]);
        end

        // Ping-pong fill, overflow, and back-to-back frames
        do_reset();
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'h0100 + DATA_W'(i);
            exp_q.push_back(wr_data);
            tick();
            if (i == 2 * FRAME_LEN - 2) chk("pp_ready_before_last", 32'(wr_ready), 32'd1);
        end
        wr_en = 1'b0;
        chk("pp_ready_full", 32'(wr_ready), 32'd0);
        chk("pp_no_overflow_yet", 32'(overflow), 32'd0);
        chk("pp_req_stalled", 32'(req_o), 32'd1);
        chk("pp_word0_held", 32'(data_o), 32'h0100);
        wr_en   = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("pp_overflow_set", 32'(overflow), 32'd1);
        chk("pp_ready_still_low", 32'(wr_ready), 32'd0);
        tick();
        chk("pp_overflow_sticky", 32'(overflow), 32'd1);
        ans_i = 1'b1;
        low   = 0;
        guard = 0;
        while (xfer_cnt < 2 * FRAME_LEN && guard < 300) begin
            tick();
            guard++;
            if (!req_o && xfer_cnt == FRAME_LEN) begin
                low++;
                if (low == 1) chk("pp_wr_ready_recover", 32'(wr_ready), 32'd1);
            end
        end
        chk("pp_gap_cycles", 32'(low), 32'd2);
        chk("pp_xfers", 32'(xfer_cnt), 32'(2 * FRAME_LEN));
        tick();
        tick();
        chk("pp_done_count", 32'(done_cnt), 32'd2);
        chk("pp_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("pp_overflow_final", 32'(overflow), 32'd1);
        ans_i = 1'b0;

        // Concurrent load while sending
        do_reset();
        ans_i = 1'b1;
        n     = 0;
        guard = 0;
        while (n < 4 * FRAME_LEN && guard < 1000) begin
            guard++;
            if (wr_ready) begin
                wr_en   = 1'b1;
                wr_data = 16'h0200 + DATA_W'(n);
                exp_q.push_back(wr_data);
                n++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        chk("cc_words_written", 32'(n), 32'(4 * FRAME_LEN));
        wait_xfers(4 * FRAME_LEN, 500);
        chk("cc_xfers", 32'(xfer_cnt), 32'(4 * FRAME_LEN));
        tick();
        tick();
        chk("cc_done_count", 32'(done_cnt), 32'd4);
        chk("cc_overflow", 32'(overflow), 32'd0);
        chk("cc_queue_empty", 32'(exp_q.size()), 32'd0);
        ans_i = 1'b0;

        // Reset in the middle of a frame
        do_reset();
        ans_i = 1'b1;
        write_frame(16'h0300);
        wait_xfers(10, 100);
        chk("mr_reached_10", 32'(xfer_cnt), 32'd10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        xfer_cnt = 0;
        done_cnt = 0;
        chk("mr_req_low", 32'(req_o), 32'd0);
        chk("mr_wr_ready", 32'(wr_ready), 32'd1);
        chk("mr_data_zero", 32'(data_o), 32'd0);
        tick();
        chk("mr_req_stays_low", 32'(req_o), 32'd0);
        write_frame(16'h0400);
        wait_xfers(FRAME_LEN, 100);
        chk("mr_xfers", 32'(xfer_cnt), 32'(FRAME_LEN));
        tick();
        tick();
        chk("mr_done_count", 32'(done_cnt), 32'd1);
        chk("mr_queue_empty", 32'(exp_q.size()), 32'd0);
        ans_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_frame_src.md
# fft_frame_src

Frame transmitter feeding the FFT core's sample input port: the initiator side of the req/ans word handshake that the core answers. Upstream logic pushes 16-bit samples through a simple write port. The block collects them into 32-word frames in a ping-pong buffer and ships each complete frame to the FFT core as one uninterrupted request burst. One frame can be loaded while the previous one is being sent.

## Interface
- `DATA_W`, 16, sample width
- `FRAME_LEN`, 32, words per frame (power of two)
- `ADDR_W`, 5, log2(FRAME_LEN)
- `clk` in 1: sole clock, all logic on posedge.
- `rst` in 1: **one clock; reset is synchronous and active-low.**
- `wr_en` in 1: upstream write strobe.
- `wr_data` in DATA_W: sample written when `wr_en && wr_ready`.
- `wr_ready` out 1: the current write bank is not full.
- `req_o` out 1: frame request to the FFT core; held high for a whole frame.
- `ans_i` in 1: core acknowledge; one word transfers per cycle where `req_o && ans_i`.
- `data_o` out DATA_W: current word of the frame; valid whenever `req_o` is high.
- `frame_done` out 1: one-cycle pulse after the last word of a frame transfers.
- `overflow` out 1: sticky; set by a write attempted while `wr_ready` is low.

## Operation
- **Storage:** two banks of FRAME_LEN × DATA_W words, plus `full[1:0]`, `wr_bank`, `rd_bank`, `wr_cnt`, `rd_cnt` (ADDR_W each). Samples are stored and sent in natural order. The FFT core performs the bit-reverse.
- **Write side**
  - `wr_ready = !full[wr_bank]`.
  - On an accepted write, `bank[wr_bank][wr_cnt] <= wr_data` and `wr_cnt++`.
  - When `wr_cnt == FRAME_LEN-1`: set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_cnt` to 0.
  - If `wr_en && !wr_ready`: data is dropped and `overflow <= 1`. Only reset clears `overflow`.
- **Send FSM**, states IDLE, SEND, GAP:
  - **IDLE:** `req_o = 0`. If `full[rd_bank]`, go to SEND and set `rd_cnt = 0`.
  - **SEND:** `req_o = 1` and `data_o = bank[rd_bank][rd_cnt]`.
    - On each cycle with `ans_i == 1`, `rd_cnt++`.
    - On the handshake where `rd_cnt == FRAME_LEN-1`: clear `full[rd_bank]`, toggle `rd_bank`, pulse `frame_done` next cycle, and go to GAP.
    - If `ans_i == 0`, the block stalls: `rd_cnt` and `data_o` are held and `req_o` stays high.
  - **GAP:** `req_o = 0` for exactly one cycle, then go to IDLE. This guarantees the core sees `req_o` fall between frames, so the core returns to its idle state.
- `ans_i` is ignored while `req_o` is low.
- **Simultaneous events:**
  - The writer setting `full` on one bank and the sender clearing `full` on the other bank in the same cycle both take effect.
  - The writer and sender never touch the same bank in the same cycle: the writer only writes a non-full bank, and the sender only reads a full bank.
- **Reset mid-operation:** FSM goes to IDLE; `full`, counters, `wr_bank`, `rd_bank` and `overflow` go to 0. Partial and queued frames are discarded. Buffer contents are not cleared.

## Timing
- **Reset values:** `req_o=0`, `data_o=0`, `frame_done=0`, `overflow=0`, `wr_ready=1`.
- **Request latency:** the last write of a frame at edge N sets `full`. FSM enters SEND at N+1, so `req_o` is high from N+1.
- **`data_o` path:** `data_o` is registered and prefetched. The word for the next `rd_cnt` is on `data_o` the cycle after each handshake, so back-to-back `ans_i` sustains one word per clock.
- **Frame duration:** with `ans_i` held high, a frame is exactly FRAME_LEN consecutive transfer cycles.
- **Inter-frame spacing:** minimum is one GAP cycle plus one IDLE cycle. With both banks full, `req_o` falls for exactly 2 cycles between frames.
- **`wr_ready` recovery:** `wr_ready` for a previously full bank returns the cycle after that bank's last handshake.

## Structure
- **Shared `fft_pkg`:** `DATA_W`, `FRAME_LEN`, `ADDR_W`, and the state encoding (IDLE=2'b00, SEND=2'b01, GAP=2'b10), shared with the FFT core's constants.
- **Sub-module `fft_pingpong_ram`:** two-bank, one-write/one-read, registered-read memory. The counters and FSM stay in the top module.

## Test plan
- **Single frame:** after reset, write 0x0000..0x001F with `ans_i` tied high → `req_o` rises the cycle after the 32nd write and `data_o` shows 0x0000..0x001F on consecutive cycles. Then `req_o` goes low, `frame_done` pulses once, and `wr_ready` stays 1 throughout.
- **Stall:** same frame, with `ans_i` low for 3 cycles after word 0x0007 → `data_o` holds 0x0008 and `req_o` stays high. The sequence resumes intact, for 32 transfers total.
- **Ping-pong / overflow:** write 64 words (0x0100..0x013F) with `ans_i` low → `wr_ready` falls after word 64. A 65th write sets `overflow` and is dropped. Releasing `ans_i` yields two frames separated by exactly 2 low cycles of `req_o`.
- **Concurrent load:** stream writes continuously while frames send with `ans_i` high → no word is lost or reordered across 4 frames, and `overflow` stays 0.
- **Reset mid-frame:** assert `rst=0` for 1 cycle after the 10th transfer → next cycle `req_o=0` and `wr_ready=1`. A fresh 32-word load sends words starting at index 0.
